// File: rtl/tcd_sched.sv
// -----------------------------------------------------------------------------
// tcd_sched
// Time-triggered DMA scheduler. A hyperperiod timer counts 0..HP-1. Each
// schedule slot holds a source address, a byte count and a release time. When
// the timer reaches a valid slot's release time, that slot becomes pending. A
// small FSM serves pending slots one at a time, lowest index first, through a
// simple cmd/busy handshake with a DMA engine.
//
// Ports
//   clock            rising-edge clock
//   reset            synchronous, active-low reset
//   enable           run schedule; 0 holds timer at 0 and blocks releases
//   cfg_we           config write strobe
//   cfg_slot         target slot of the config write
//   cfg_field        0 addr, 1 nbytes, 2 release (sets valid), 3 hyperperiod,
//                    4 clear valid, 5 clear overrun bits by mask
//   cfg_data         config value (timer fields use low TIMER_WIDTH bits)
//   dma_addr_out     latched source address of the slot in service
//   dma_nbytes_out   latched byte count of the slot in service
//   dma_cmd_out      DMA request, high only while issuing
//   dma_status_in    DMA busy
//   timer_out        current timer value
//   active_slot_out  slot most recently dispatched
//   overrun_out      sticky per-slot overrun flags
//   done_out         one-cycle pulse when a transfer completes
// -----------------------------------------------------------------------------
module tcd_sched #(
    parameter int MEMORY_BUS_WIDTH = 32,
    parameter int NUM_SLOTS        = 4,
    parameter int TIMER_WIDTH      = 16,
    localparam int SLOT_W          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        cfg_we,
    input  logic [SLOT_W-1:0]           cfg_slot,
    input  logic [2:0]                  cfg_field,
    input  logic [MEMORY_BUS_WIDTH-1:0] cfg_data,
    output logic [MEMORY_BUS_WIDTH-1:0] dma_addr_out,
    output logic [MEMORY_BUS_WIDTH-1:0] dma_nbytes_out,
    output logic                        dma_cmd_out,
    input  logic                        dma_status_in,
    output logic [TIMER_WIDTH-1:0]      timer_out,
    output logic [SLOT_W-1:0]           active_slot_out,
    output logic [NUM_SLOTS-1:0]        overrun_out,
    output logic                        done_out
);

    localparam logic [2:0] FIELD_ADDR    = 3'd0;
    localparam logic [2:0] FIELD_NBYTES  = 3'd1;
    localparam logic [2:0] FIELD_RELEASE = 3'd2;
    localparam logic [2:0] FIELD_HP      = 3'd3;
    localparam logic [2:0] FIELD_CLRVAL  = 3'd4;
    localparam logic [2:0] FIELD_CLROVR  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;

    logic [MEMORY_BUS_WIDTH-1:0] r_addr    [NUM_SLOTS];
    logic [MEMORY_BUS_WIDTH-1:0] r_nbytes  [NUM_SLOTS];
    logic [TIMER_WIDTH-1:0]      r_release [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]        r_valid;
    logic [NUM_SLOTS-1:0]        r_pending;
    logic [NUM_SLOTS-1:0]        r_overrun;

    logic [TIMER_WIDTH-1:0]      r_timer;
    logic [TIMER_WIDTH-1:0]      w_timer_next;
    logic [TIMER_WIDTH-1:0]      r_hp;

    logic [MEMORY_BUS_WIDTH-1:0] r_dma_addr;
    logic [MEMORY_BUS_WIDTH-1:0] r_dma_nbytes;
    logic [SLOT_W-1:0]           r_active;
    logic                        r_done;
    logic                        w_dma_cmd;
    logic                        w_done_next;

    logic [NUM_SLOTS-1:0]        w_cfg_hit;
    logic [NUM_SLOTS-1:0]        w_release;
    logic [NUM_SLOTS-1:0]        w_in_service;
    logic [NUM_SLOTS-1:0]        w_clr_valid;
    logic [NUM_SLOTS-1:0]        w_new_overrun;
    logic [NUM_SLOTS-1:0]        w_new_pending;
    logic [NUM_SLOTS-1:0]        w_ovr_clr;
    logic [NUM_SLOTS-1:0]        w_grant;
    logic [SLOT_W-1:0]           w_grant_idx;
    logic                        w_dispatch;

    // ---------------------------------------------------------------------
    // Per-slot release / overrun decode
    // ---------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign w_cfg_hit[gi]     = cfg_we && (cfg_slot == SLOT_W'(gi));
            assign w_clr_valid[gi]   = w_cfg_hit[gi] && (cfg_field == FIELD_CLRVAL);
            assign w_release[gi]     = enable && r_valid[gi] && (r_timer == r_release[gi]);
            // "In service" covers both ISSUE and WAIT_DONE of this slot.
            assign w_in_service[gi]  = (r_state != ST_IDLE) && (r_active == SLOT_W'(gi));
            assign w_new_overrun[gi] = w_release[gi] && (r_pending[gi] || w_in_service[gi]);
            // A second release never queues; only an idle slot becomes pending.
            assign w_new_pending[gi] = w_release[gi] && !r_pending[gi] && !w_in_service[gi];
        end
    endgenerate

    assign w_ovr_clr = (cfg_we && (cfg_field == FIELD_CLROVR)) ? cfg_data[NUM_SLOTS-1:0]
                                                               : '0;

    // Lowest-index pending slot wins the dispatch.
    always_comb begin
        w_grant_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_grant_idx = SLOT_W'(i);
            end
        end
    end

    assign w_dispatch = (r_state == ST_IDLE) && (|r_pending);
    assign w_grant    = w_dispatch ? (NUM_SLOTS'(1) << w_grant_idx) : '0;

    // ---------------------------------------------------------------------
    // Slot configuration table
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_addr[i]    <= '0;
                r_nbytes[i]  <= '0;
                r_release[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_cfg_hit[i]) begin
                    case (cfg_field)
                        FIELD_ADDR:    r_addr[i]    <= cfg_data;
                        FIELD_NBYTES:  r_nbytes[i]  <= cfg_data;
                        FIELD_RELEASE: begin
                            r_release[i] <= cfg_data[TIMER_WIDTH-1:0];
                            r_valid[i]   <= 1'b1;
                        end
                        FIELD_CLRVAL:  r_valid[i]   <= 1'b0;
                        default: ;
                    endcase
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Pending and sticky overrun flags
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pending <= '0;
            r_overrun <= '0;
        end else begin
            // Clearing valid drops the pending bit even if a release lands now.
            r_pending <= ((r_pending & ~w_grant) | w_new_pending) & ~w_clr_valid;
            // New overrun wins over a same-cycle clear.
            r_overrun <= (r_overrun & ~w_ovr_clr) | w_new_overrun;
        end
    end

    // ---------------------------------------------------------------------
    // Hyperperiod timer
    // ---------------------------------------------------------------------
    always_comb begin
        w_timer_next = '0;
        if (enable && (r_hp > TIMER_WIDTH'(1))) begin
            // ">=" also catches a timer left beyond a freshly shortened period.
            if (r_timer >= (r_hp - TIMER_WIDTH'(1))) begin
                w_timer_next = '0;
            end else begin
                w_timer_next = r_timer + TIMER_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_timer <= '0;
            r_hp    <= TIMER_WIDTH'(20);
        end else begin
            r_timer <= w_timer_next;
            if (cfg_we && (cfg_field == FIELD_HP)) begin
                r_hp <= cfg_data[TIMER_WIDTH-1:0];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Dispatch FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_dma_cmd    = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|r_pending) begin
                    w_state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_dma_cmd = 1'b1;
                if (dma_status_in) begin
                    w_state_next = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (!dma_status_in) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Transfer parameters are captured at dispatch so later config writes to
    // the same slot cannot disturb an in-flight transfer.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_dma_addr   <= '0;
            r_dma_nbytes <= '0;
            r_active     <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_dispatch) begin
                r_dma_addr   <= r_addr[w_grant_idx];
                r_dma_nbytes <= r_nbytes[w_grant_idx];
                r_active     <= w_grant_idx;
            end
        end
    end

    assign dma_addr_out    = r_dma_addr;
    assign dma_nbytes_out  = r_dma_nbytes;
    assign dma_cmd_out     = w_dma_cmd;
    assign timer_out       = r_timer;
    assign active_slot_out = r_active;
    assign overrun_out     = r_overrun;
    assign done_out        = r_done;

endmodule

// File: tb/tb_tcd_sched.sv
module tb_tcd_sched;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_slot = '0;
    logic [2:0]  cfg_field = '0;
    logic [31:0] cfg_data = '0;
    logic [31:0] dma_addr_out;
    logic [31:0] dma_nbytes_out;
    logic        dma_cmd_out;
    logic        dma_status_in = 1'b0;
    logic [15:0] timer_out;
    logic [1:0]  active_slot_out;
    logic [3:0]  overrun_out;
    logic        done_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] nbytes;
        logic [1:0]  slot;
    } exp_t;
    exp_t sb[$];

    tcd_sched dut (
        .clock          (clock),
        .reset          (reset),
        .enable         (enable),
        .cfg_we         (cfg_we),
        .cfg_slot       (cfg_slot),
        .cfg_field      (cfg_field),
        .cfg_data       (cfg_data),
        .dma_addr_out   (dma_addr_out),
        .dma_nbytes_out (dma_nbytes_out),
        .dma_cmd_out    (dma_cmd_out),
        .dma_status_in  (dma_status_in),
        .timer_out      (timer_out),
        .active_slot_out(active_slot_out),
        .overrun_out    (overrun_out),
        .done_out       (done_out)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input logic [1:0] slot, input logic [2:0] field, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_slot  = slot;
        cfg_field = field;
        cfg_data  = data;
        tick();
        cfg_we    = 1'b0;
        $display("cfg slot=%0d field=%0d data=0x%0h", slot, field, data);
    endtask

    task automatic wait_timer(input logic [15:0] val, input int budget);
        int n = 0;
        while (timer_out !== val && n < budget) begin
            tick();
            n++;
        end
        check("timer_reach", timer_out, 32'(val));
    endtask

    // Waits for a DMA request and compares it with the head of the scoreboard.
    task automatic wait_cmd(input int budget);
        int   n = 0;
        exp_t e;
        while (dma_cmd_out !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        check("cmd_seen", 32'(dma_cmd_out), 32'd1);
        check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("dispatch_addr", dma_addr_out, e.addr);
            check("dispatch_nbytes", dma_nbytes_out, e.nbytes);
            check("dispatch_slot", 32'(active_slot_out), 32'(e.slot));
            $display("dispatch slot=%0d addr=0x%0h nbytes=%0d timer=%0d",
                     active_slot_out, dma_addr_out, dma_nbytes_out, timer_out);
        end
    endtask

    // DMA reports busy for n cycles, then idle; expects one done pulse.
    task automatic busy(input int n);
        dma_status_in = 1'b1;
        tick();
        for (int i = 1; i < n; i++) begin
            check("busy_quiet", {30'd0, dma_cmd_out, done_out}, 32'd0);
            tick();
        end
        dma_status_in = 1'b0;
        tick();
        check("done_pulse", 32'(done_out), 32'd1);
        tick();
        check("done_single", 32'(done_out), 32'd0);
        $display("transfer complete timer=%0d", timer_out);
    endtask

    initial begin
        // ---- reset state ----
        tick();
        tick();
        check("rst_addr", dma_addr_out, 32'd0);
        check("rst_nbytes", dma_nbytes_out, 32'd0);
        check("rst_cmd", 32'(dma_cmd_out), 32'd0);
        check("rst_done", 32'(done_out), 32'd0);
        check("rst_active", 32'(active_slot_out), 32'd0);
        check("rst_timer", 32'(timer_out), 32'd0);
        check("rst_overrun", 32'(overrun_out), 32'd0);
        reset = 1'b1;
        tick();

        // ---- single dispatch, latency and latched outputs ----
        cfg(2'd0, 3'd0, 32'h100);
        cfg(2'd0, 3'd1, 32'd64);
        cfg(2'd0, 3'd2, 32'd5);
        sb.push_back('{32'h100, 32'd64, 2'd0});
        enable = 1'b1;
        tick();
        check("timer_runs", 32'(timer_out), 32'd1);
        wait_timer(16'd5, 40);
        tick();
        check("cmd_not_yet", 32'(dma_cmd_out), 32'd0);
        tick();
        wait_cmd(0);
        cfg(2'd0, 3'd0, 32'h200);
        check("addr_held", dma_addr_out, 32'h100);
        check("cmd_held", 32'(dma_cmd_out), 32'd1);
        cfg(2'd0, 3'd4, 32'd0);
        busy(10);
        check("idle_after_done", 32'(dma_cmd_out), 32'd0);
        enable = 1'b0;
        tick();
        check("timer_held", 32'(timer_out), 32'd0);

        // ---- two slots released together, lowest index first ----
        cfg(2'd0, 3'd2, 32'd3);
        cfg(2'd2, 3'd0, 32'h300);
        cfg(2'd2, 3'd1, 32'd16);
        cfg(2'd2, 3'd2, 32'd3);
        sb.push_back('{32'h200, 32'd64, 2'd0});
        sb.push_back('{32'h300, 32'd16, 2'd2});
        enable = 1'b1;
        wait_cmd(40);
        cfg(2'd0, 3'd4, 32'd0);
        busy(4);
        wait_cmd(10);
        cfg(2'd2, 3'd4, 32'd0);
        busy(3);
        check("no_overrun_b", 32'(overrun_out), 32'd0);
        enable = 1'b0;
        tick();

        // ---- overrun while in service, clear by mask ----
        cfg(2'd0, 3'd3, 32'd8);
        cfg(2'd1, 3'd0, 32'h400);
        cfg(2'd1, 3'd1, 32'd8);
        cfg(2'd1, 3'd2, 32'd2);
        sb.push_back('{32'h400, 32'd8, 2'd1});
        enable = 1'b1;
        wait_cmd(30);
        check("ovr_clear_start", 32'(overrun_out), 32'd0);
        dma_status_in = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        check("ovr_set", 32'(overrun_out), 32'h2);
        check("cmd_low_wait", 32'(dma_cmd_out), 32'd0);
        cfg(2'd0, 3'd5, 32'h2);
        check("ovr_cleared", 32'(overrun_out), 32'd0);
        wait_timer(16'd2, 20);
        cfg(2'd0, 3'd5, 32'h2);
        check("ovr_new_wins", 32'(overrun_out), 32'h2);
        cfg(2'd0, 3'd5, 32'hF);
        check("ovr_cleared2", 32'(overrun_out), 32'd0);
        cfg(2'd1, 3'd4, 32'd0);
        dma_status_in = 1'b0;
        tick();
        check("done_c", 32'(done_out), 32'd1);
        tick();
        check("done_c_single", 32'(done_out), 32'd0);
        check("no_redispatch", 32'(dma_cmd_out), 32'd0);
        enable = 1'b0;
        tick();

        // ---- hyperperiod shortened below the current timer ----
        cfg(2'd0, 3'd3, 32'd20);
        enable = 1'b1;
        wait_timer(16'd14, 40);
        cfg(2'd0, 3'd3, 32'd10);
        check("hp_before_wrap", 32'(timer_out), 32'd15);
        tick();
        check("hp_wrap", 32'(timer_out), 32'd0);
        for (int i = 0; i < 9; i++) tick();
        check("hp_top", 32'(timer_out), 32'd9);
        tick();
        check("hp_period", 32'(timer_out), 32'd0);
        cfg(2'd0, 3'd3, 32'd1);
        tick();
        check("hp1_hold_a", 32'(timer_out), 32'd0);
        tick();
        check("hp1_hold_b", 32'(timer_out), 32'd0);
        cfg(2'd0, 3'd3, 32'd10);

        // ---- reset during WAIT_DONE ----
        cfg(2'd3, 3'd0, 32'h500);
        cfg(2'd3, 3'd1, 32'd32);
        cfg(2'd3, 3'd2, 32'd1);
        sb.push_back('{32'h500, 32'd32, 2'd3});
        wait_cmd(30);
        dma_status_in = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        dma_status_in = 1'b0;
        tick();
        check("mid_rst_cmd", 32'(dma_cmd_out), 32'd0);
        check("mid_rst_done", 32'(done_out), 32'd0);
        check("mid_rst_addr", dma_addr_out, 32'd0);
        check("mid_rst_nbytes", dma_nbytes_out, 32'd0);
        check("mid_rst_active", 32'(active_slot_out), 32'd0);
        check("mid_rst_timer", 32'(timer_out), 32'd0);
        reset = 1'b1;
        enable = 1'b0;
        tick();
        check("post_rst_done", 32'(done_out), 32'd0);
        check("post_rst_cmd", 32'(dma_cmd_out), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/tcd_sched.md
TCD_SCHED -- requirements
Module: tcd_sched

Interface
REQ-001 SHALL have parameter MEMORY_BUS_WIDTH, default 32, width of address/size/config data.
REQ-002 SHALL have parameter NUM_SLOTS, default 4, number of schedule table entries (>=1).
REQ-003 SHALL have parameter TIMER_WIDTH, default 16, width of the hyperperiod timer.
REQ-004 SHALL have port clock  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  schedule run; 0 holds timer at 0 and blocks new releases.
REQ-007 SHALL have port cfg_we  input  1  config write strobe, one write per cycle.
REQ-008 SHALL have port cfg_slot  input  $clog2(NUM_SLOTS) (min 1)  target slot.
REQ-009 SHALL have port cfg_field  input  3  0=addr, 1=nbytes, 2=release time (sets slot valid), 3=hyperperiod, 4=clear slot valid, 5=clear overrun bits by mask.
REQ-010 SHALL have port cfg_data  input  MEMORY_BUS_WIDTH  config value; timer fields use low TIMER_WIDTH bits.
REQ-011 SHALL have port dma_addr_out  output  MEMORY_BUS_WIDTH  source address to DMA.
REQ-012 SHALL have port dma_nbytes_out  output  MEMORY_BUS_WIDTH  byte count to DMA.
REQ-013 SHALL have port dma_cmd_out  output  1  DMA request.
REQ-014 SHALL have port dma_status_in  input  1  DMA busy (1 = transfer in progress).
REQ-015 SHALL have port timer_out  output  TIMER_WIDTH  current timer value.
REQ-016 SHALL have port active_slot_out  output  $clog2(NUM_SLOTS) (min 1)  slot in service.
REQ-017 SHALL have port overrun_out  output  NUM_SLOTS  sticky per-slot overrun flags.
REQ-018 SHALL have port done_out  output  1  one-cycle pulse on transfer completion.

Function
REQ-019 Timer SHALL count 0..HP-1 then wrap to 0 while enable=1; HP=0 or HP=1 SHALL hold timer at 0.
REQ-020 A hyperperiod write SHALL take effect next cycle; if timer >= new HP, timer SHALL wrap to 0 on the next increment.
REQ-021 A slot SHALL become pending in the cycle after timer==release, enable=1, slot valid.
REQ-022 Release on a slot already pending or in service SHALL set its overrun bit; pending stays single (no queueing).
REQ-023 FSM states: IDLE, ISSUE, WAIT_DONE.
REQ-024 IDLE: if any slot pending, SHALL select lowest-index pending slot, latch its addr/nbytes into dma_addr_out/dma_nbytes_out, clear its pending bit, set active_slot_out, go to ISSUE.
REQ-025 ISSUE: dma_cmd_out=1; SHALL stay until dma_status_in=1, then go to WAIT_DONE.
REQ-026 WAIT_DONE: dma_cmd_out=0; on dma_status_in=0 SHALL pulse done_out one cycle and go to IDLE.
REQ-027 dma_cmd_out SHALL be 1 only in ISSUE.
REQ-028 Config writes to addr/nbytes of the slot in service SHALL NOT alter the in-flight latched DMA outputs.
REQ-029 Clearing slot valid SHALL also clear its pending bit; it SHALL NOT abort an in-flight transfer.
REQ-030 Clear-overrun (field 5) SHALL clear bits set in cfg_data[NUM_SLOTS-1:0]; a same-cycle new overrun SHALL win.
REQ-031 enable falling SHALL NOT abort an in-flight transfer; pending slots remain pending and dispatch.

Reset
REQ-032 reset=0 at a rising edge SHALL set: FSM IDLE, timer 0, HP 20, all slots invalid, addr/nbytes/release 0, pending 0, overrun_out 0, dma_addr_out 0, dma_nbytes_out 0, dma_cmd_out 0, done_out 0, active_slot_out 0.
REQ-033 Reset mid-transfer SHALL drop dma_cmd_out the next cycle regardless of dma_status_in.

Verification
REQ-034 Slot0 addr=0x100, nbytes=64, release=5, HP=20, enable -> dma_cmd_out rises 2 cycles after timer==5 with addr 0x100/nbytes 64; DMA busy 10 cycles -> done_out pulse, FSM IDLE.
REQ-035 Slots 0 and 2 both release=3 -> slot 0 dispatched first, slot 2 after slot 0 done_out.
REQ-036 Slot1 release=2, HP=8, DMA held busy 12 cycles -> overrun_out[1]=1 on next timer==2; field 5 mask 0x2 -> bit clears.
REQ-037 HP=20, timer=15, write HP=10 -> timer wraps to 0 on next increment; thereafter period 10.
REQ-038 Assert reset while in WAIT_DONE -> all outputs at reset values next cycle, no done_out pulse.
REQ-039 Rewrite slot0 addr to 0x200 during ISSUE -> dma_addr_out stays 0x100 until next dispatch.
